// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge gate-drive conditioner.
// Holds the leg-state enum, the pattern bit positions and the request encoding.
package bridge_pkg;

  // Per-leg FSM state.
  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HIGH = 2'd1,
    LEG_LOW  = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_e;

  // Decoded request for one half-bridge leg.
  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_H       = 2'd1,
    REQ_L       = 2'd2,
    REQ_ILLEGAL = 2'd3
  } leg_req_e;

  // Bit positions inside the sequencer pattern and the gate output word.
  localparam int PAT_AH   = 7;
  localparam int PAT_AL   = 6;
  localparam int PAT_BH   = 5;
  localparam int PAT_BL   = 4;
  localparam int PAT_CH   = 3;
  localparam int PAT_CL   = 2;
  localparam int NUM_LEGS = 3;

  // Classify one leg's request bits. Both bits set is always illegal, even
  // with the bridge disabled, so a misbehaving sequencer is still flagged.
  function automatic leg_req_e decode_req(input logic hi, input logic lo, input logic en);
    leg_req_e r;
    if (hi && lo)   r = REQ_ILLEGAL;
    else if (!en)   r = REQ_NONE;
    else if (hi)    r = REQ_H;
    else if (lo)    r = REQ_L;
    else            r = REQ_NONE;
    return r;
  endfunction

  // State a leg settles into once it is allowed to act on a request.
  function automatic leg_state_e req_target(input leg_req_e r);
    leg_state_e s;
    case (r)
      REQ_H:   s = LEG_HIGH;
      REQ_L:   s = LEG_LOW;
      default: s = LEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bridge_leg_dt.sv
// One half-bridge leg: request FSM, dead-time counter and registered gate decode.
// The two gates come from a single state register, so they can never both be on.
module bridge_leg_dt
  import bridge_pkg::*;
#(
  parameter int DT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_h_i,
  input  logic req_l_i,
  input  logic pwm_on_i,   // PWM phase for the cycle the registered gates will drive
  input  logic ena_i,
  output logic gate_h_o,
  output logic gate_l_o
);

  localparam logic [3:0] DT_LOAD = 4'(DT_CYCLES - 1);

  leg_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  leg_req_e   req_q;
  leg_req_e   req_raw;
  leg_req_e   req_eff;
  logic       gate_h_q, gate_l_q;

  // An illegal request drives the leg exactly like "no request".
  always_comb begin
    req_raw = decode_req(req_h_i, req_l_i, ena_i);
    req_eff = (req_raw == REQ_ILLEGAL) ? REQ_NONE : req_raw;
  end

  // Next-state logic. Any request change while in DEAD (ena toggling included)
  // restarts the dead time, so the full gap is always counted from the last change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LEG_OFF: begin
        state_d = req_target(req_eff);
      end
      LEG_HIGH: begin
        if (req_eff != REQ_H) begin
          state_d = LEG_DEAD;
          cnt_d   = DT_LOAD;
        end
      end
      LEG_LOW: begin
        if (req_eff != REQ_L) begin
          state_d = LEG_DEAD;
          cnt_d   = DT_LOAD;
        end
      end
      LEG_DEAD: begin
        if (req_eff != req_q) begin
          cnt_d = DT_LOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = req_target(req_eff);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = LEG_OFF;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state, counter, last request and gate outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LEG_OFF;
      cnt_q    <= 4'd0;
      req_q    <= REQ_NONE;
      gate_h_q <= 1'b0;
      gate_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_eff;
      gate_h_q <= (state_d == LEG_HIGH) && pwm_on_i;
      gate_l_q <= (state_d == LEG_LOW);
    end
  end

  assign gate_h_o = gate_h_q;
  assign gate_l_o = gate_l_q;

endmodule

// File: rtl/bridge_gate_ctrl.sv
// Gate-drive conditioner between the 6-step sequencer and the bridge pins.
// Optional build macro: BRIDGE_PWM_EN enables high-side PWM chopping; without it
// the high side follows the leg state directly and the duty input is ignored.
module bridge_gate_ctrl
  import bridge_pkg::*;
#(
  parameter int DT_CYCLES = 4,
  parameter int PWM_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       pat_in,
  input  logic [PWM_W-1:0] duty,
  output logic [7:0]       gate_out,
  output logic             fault
);

  logic                pwm_on;
  logic [NUM_LEGS-1:0] leg_h;
  logic [NUM_LEGS-1:0] leg_l;
  logic [NUM_LEGS-1:0] leg_ill;
  logic                fault_q;

`ifdef BRIDGE_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             unused_pat;

  // The counter wraps naturally; duty is only picked up on the wrap so a
  // period is never cut short or stretched by a mid-period change.
  assign pwm_cnt_d = pwm_cnt_q + {{(PWM_W-1){1'b0}}, 1'b1};
  assign duty_d    = (pwm_cnt_q == {PWM_W{1'b1}}) ? duty : duty_q;
  // Evaluated on next-cycle values because the legs register their gates.
  assign pwm_on    = (pwm_cnt_d < duty_d);
  assign unused_pat = ^pat_in[1:0];

  // Free-running PWM counter and duty shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
    end
  end
`else
  logic unused_in;

  assign pwm_on    = 1'b1;
  assign unused_in = ^{duty, pat_in[1:0]};
`endif

  // Three identical legs sliced out of the pattern word (A at the top).
  for (genvar gi = 0; gi < NUM_LEGS; gi++) begin : g_leg
    localparam int HI_IDX = PAT_AH - 2 * gi;
    localparam int LO_IDX = HI_IDX - 1;

    bridge_leg_dt #(
      .DT_CYCLES(DT_CYCLES)
    ) u_leg (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_h_i  (pat_in[HI_IDX]),
      .req_l_i  (pat_in[LO_IDX]),
      .pwm_on_i (pwm_on),
      .ena_i    (ena),
      .gate_h_o (leg_h[gi]),
      .gate_l_o (leg_l[gi])
    );

    assign leg_ill[gi] = (decode_req(pat_in[HI_IDX], pat_in[LO_IDX], ena) == REQ_ILLEGAL);
  end

  // Reassemble leg gates into the pin word; the two spare bits stay low.
  always_comb begin
    gate_out = 8'h00;
    for (int i = 0; i < NUM_LEGS; i++) begin
      gate_out[PAT_AH - 2 * i] = leg_h[i];
      gate_out[PAT_AL - 2 * i] = leg_l[i];
    end
  end

  // Sticky fault: any illegal leg request latches until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (|leg_ill) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;

endmodule
